// File: rtl/conway_pkg.sv
// Shared board geometry and types for the Conway board and its display stage.
// Cell k of a board lives at row k[5:3], column k[2:0].
package conway_pkg;

  localparam int BOARD_DIM   = 8;
  localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;

  typedef logic [BOARD_CELLS-1:0] board_t;
  typedef logic [2:0]             row_idx_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_RUN
  } cap_state_e;

  // One row of the board as column bits, bit i = column i.
  function automatic logic [BOARD_DIM-1:0] row_bits(input board_t board, input row_idx_t row);
    return board[{row, 3'b000} +: BOARD_DIM];
  endfunction

  // One-hot active-low row enable for the given row.
  function automatic logic [BOARD_DIM-1:0] row_enable_n(input row_idx_t row);
    logic [BOARD_DIM-1:0] one_hot;
    one_hot = '0;
    one_hot[row] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/conway_row_scanner.sv
// Row multiplex timing: prescaler, row counter, dead-time and frame-wrap decode.
// row_wrap marks the cycle whose rising edge moves the row counter from 7 to 0.
module conway_row_scanner
  import conway_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  output row_idx_t row,
  output logic     row_wrap,
  output logic     dead
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam row_idx_t    LAST_ROW  = row_idx_t'(BOARD_DIM - 1);
  localparam row_idx_t    ROW_STEP  = row_idx_t'(1);

  logic [15:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      row   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      row   <= row + ROW_STEP;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // The first cycle of every row period is dead time so the previous row's
  // column data never ghosts onto the newly enabled row.
  assign dead     = (presc == 16'd0);
  assign row_wrap = (presc == PRESC_MAX) && (row == LAST_ROW);

endmodule

// File: rtl/conway_led_matrix_driver.sv
// Captures the board's serial cell stream and multiplex-scans complete frames
// onto an 8x8 LED matrix; frames change only at the row 7->0 wrap (no tearing).
module conway_led_matrix_driver
  import conway_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1024,
  parameter bit          COL_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_sync,
  input  logic                 blank,
  output logic [BOARD_DIM-1:0] row_n,
  output logic [BOARD_DIM-1:0] col,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int                   IDX_W    = $clog2(BOARD_CELLS);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BOARD_CELLS - 1);
  localparam logic [BOARD_DIM-1:0] COL_MASK = {BOARD_DIM{COL_ACTIVE_LOW}};

  cap_state_e       state;
  logic [IDX_W-1:0] idx;
  board_t           cap_buf;
  board_t           frame_buf;
  board_t           disp_buf;
  logic             pending;
  logic             accept_last;

  row_idx_t row;
  logic     row_wrap;
  logic     dead;

  conway_row_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk     (clk),
    .rst_n   (rst_n),
    .row     (row),
    .row_wrap(row_wrap),
    .dead    (dead)
  );

  assign accept_last = bit_valid && !frame_sync && (state == CAP_RUN) && (idx == LAST_IDX);

  // cap_buf fills bit by bit; frame_buf only ever holds the latest complete
  // frame, so a partial or aborted capture can never reach the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CAP_IDLE;
      idx        <= '0;
      cap_buf    <= '0;
      frame_buf  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          CAP_IDLE: begin
            if (frame_sync) begin
              cap_buf <= board_t'(bit_in);
              idx     <= IDX_ONE;
              state   <= CAP_RUN;
            end
          end
          CAP_RUN: begin
            if (frame_sync) begin
              cap_buf   <= board_t'(bit_in);
              idx       <= IDX_ONE;
              frame_err <= 1'b1;
            end else begin
              cap_buf[idx] <= bit_in;
              idx          <= idx + IDX_ONE;
              if (idx == LAST_IDX) begin
                state      <= CAP_IDLE;
                frame_buf  <= {bit_in, cap_buf[BOARD_CELLS-2:0]};
                frame_done <= 1'b1;
              end
            end
          end
          default: state <= CAP_IDLE;
        endcase
      end
    end
  end

  // A completion coinciding with the wrap misses this copy (frame_buf is
  // updated on the same edge) and stays pending for the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      disp_buf <= '0;
    end else begin
      if (row_wrap && pending) begin
        disp_buf <= frame_buf;
      end
      pending <= accept_last || (pending && !row_wrap);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n <= '1;
      col   <= COL_MASK;
    end else begin
      row_n <= (dead || blank) ? '1 : row_enable_n(row);
      col   <= row_bits(disp_buf, row) ^ COL_MASK;
    end
  end

endmodule

// File: tb/tb_conway_led_matrix_driver.sv
// Directed bench for conway_led_matrix_driver: two instances (fast scan, and slow
// scan with inverted columns) share stimulus and are checked against a scoreboard.
module tb_conway_led_matrix_driver;

  localparam int DIV[2]    = '{4, 32};
  localparam bit COL_AL[2] = '{1'b0, 1'b1};

  typedef struct packed {
    logic [7:0] row_n;
    logic [7:0] col;
    logic       done;
    logic       err;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_sync;
  logic       blank;
  logic [7:0] row_n_o[2];
  logic [7:0] col_o[2];
  logic       done_o[2];
  logic       err_o[2];

  int checks;
  int failures;
  int done_cnt[2];
  int err_cnt[2];

  obs_t        exp_q[$];
  logic [63:0] m_cap;
  logic [63:0] m_frame;
  logic [63:0] m_disp[2];
  bit          m_pend[2];
  bit          m_run;
  int          m_idx;
  int          cyc;
  int          last_row[2];
  int          last_presc[2];

  int          d0;
  int          e0;
  int          guard;
  logic [63:0] frame_a;
  logic [63:0] frame_b;
  logic [63:0] frame_c;

  conway_led_matrix_driver #(
    .SCAN_DIV      (4),
    .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .frame_sync(frame_sync),
    .blank     (blank),
    .row_n     (row_n_o[0]),
    .col       (col_o[0]),
    .frame_done(done_o[0]),
    .frame_err (err_o[0])
  );

  conway_led_matrix_driver #(
    .SCAN_DIV      (32),
    .COL_ACTIVE_LOW(1'b1)
  ) dut_slow (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .frame_sync(frame_sync),
    .blank     (blank),
    .row_n     (row_n_o[1]),
    .col       (col_o[1]),
    .frame_done(done_o[1]),
    .frame_err (err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetModel();
    m_cap   = '0;
    m_frame = '0;
    m_run   = 1'b0;
    m_idx   = 0;
    cyc     = 0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_disp[i]     = '0;
      m_pend[i]     = 1'b0;
      last_row[i]   = 0;
      last_presc[i] = 0;
    end
  endtask

  task automatic checkOutput();
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("[TB] FAIL scoreboard_empty inst=%0d observed=%0d expected=>0", i, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (row_n_o[i] === e.row_n) else begin
          failures++;
          $error("[TB] FAIL row_n inst=%0d cyc=%0d observed=%h expected=%h", i, cyc, row_n_o[i], e.row_n);
        end
        checks++;
        assert (col_o[i] === e.col) else begin
          failures++;
          $error("[TB] FAIL col inst=%0d cyc=%0d observed=%h expected=%h", i, cyc, col_o[i], e.col);
        end
        checks++;
        assert (done_o[i] === e.done) else begin
          failures++;
          $error("[TB] FAIL frame_done inst=%0d cyc=%0d observed=%b expected=%b", i, cyc, done_o[i], e.done);
        end
        checks++;
        assert (err_o[i] === e.err) else begin
          failures++;
          $error("[TB] FAIL frame_err inst=%0d cyc=%0d observed=%b expected=%b", i, cyc, err_o[i], e.err);
        end
      end
      if (done_o[i] === 1'b1) done_cnt[i]++;
      if (err_o[i] === 1'b1) err_cnt[i]++;
    end
  endtask

  // Drive one cycle of inputs, advance the reference model on the same edge,
  // queue the expected outputs, then compare them on the falling edge.
  task automatic applyStimulus(input logic b, input logic v, input logic s, input logic bl);
    obs_t e;
    bit   complete;
    bit   done;
    bit   err;
    int   presc;
    int   row;
    bit_in     = b;
    bit_valid  = v;
    frame_sync = s;
    blank      = bl;
    @(posedge clk);
    complete = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    if (v) begin
      if (!m_run) begin
        if (s) begin
          m_cap    = '0;
          m_cap[0] = b;
          m_idx    = 1;
          m_run    = 1'b1;
        end
      end else if (s) begin
        err      = 1'b1;
        m_cap    = '0;
        m_cap[0] = b;
        m_idx    = 1;
      end else begin
        m_cap[m_idx] = b;
        if (m_idx == 63) begin
          complete = 1'b1;
          done     = 1'b1;
          m_run    = 1'b0;
          m_idx    = 0;
        end else begin
          m_idx++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      presc   = cyc % DIV[i];
      row     = (cyc / DIV[i]) % 8;
      e.row_n = (presc == 0 || bl) ? 8'hFF : ~(8'h01 << row);
      e.col   = COL_AL[i] ? ~m_disp[i][row*8 +: 8] : m_disp[i][row*8 +: 8];
      e.done  = done;
      e.err   = err;
      exp_q.push_back(e);
      last_row[i]   = row;
      last_presc[i] = presc;
      if ((cyc % (8 * DIV[i]) == 8 * DIV[i] - 1) && m_pend[i]) begin
        m_disp[i] = m_frame;
        m_pend[i] = 1'b0;
      end
      if (complete) m_pend[i] = 1'b1;
    end
    if (complete) m_frame = m_cap;
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [63:0] data, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      applyStimulus(data[k], 1'b1, (k == 0), 1'b0);
    end
  endtask

  // Scan forward to the next live (non-dead) cycle of the given row and check
  // that row's column byte; expected is the logical (active-high) row content.
  task automatic checkRowCol(input int inst, input int r, input logic [7:0] expected, input string tag);
    logic [7:0] want;
    int         n;
    want = COL_AL[inst] ? ~expected : expected;
    n    = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!(last_row[inst] == r && last_presc[inst] != 0) && n < 8 * DIV[inst] + 2);
    checks++;
    assert (last_row[inst] == r && last_presc[inst] != 0) else begin
      failures++;
      $error("[TB] FAIL %s_timeout inst=%0d observed_row=%0d expected_row=%0d", tag, inst, last_row[inst], r);
    end
    checks++;
    assert (col_o[inst] === want) else begin
      failures++;
      $error("[TB] FAIL %s inst=%0d row=%0d observed=%h expected=%h", tag, inst, r, col_o[inst], want);
    end
  endtask

  task automatic checkReset(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (row_n_o[i] === 8'hFF) else begin
        failures++;
        $error("[TB] FAIL %s_row_n inst=%0d observed=%h expected=ff", tag, i, row_n_o[i]);
      end
      checks++;
      assert (col_o[i] === (COL_AL[i] ? 8'hFF : 8'h00)) else begin
        failures++;
        $error("[TB] FAIL %s_col inst=%0d observed=%h expected=%h", tag, i, col_o[i], COL_AL[i] ? 8'hFF : 8'h00);
      end
      checks++;
      assert (done_o[i] === 1'b0 && err_o[i] === 1'b0) else begin
        failures++;
        $error("[TB] FAIL %s_pulses inst=%0d observed=%b%b expected=00", tag, i, done_o[i], err_o[i]);
      end
    end
  endtask

  task automatic checkCount(input int observed, input int expected, input string tag);
    checks++;
    assert (observed == expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    done_cnt    = '{0, 0};
    err_cnt     = '{0, 0};
    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_sync  = 1'b0;
    blank       = 1'b0;
    frame_a     = 64'h1122334455667788;
    frame_b     = 64'h99AABBCCDDEEFF00;
    frame_c     = 64'hDEADBEEFCAFEF00D;
    resetModel();

    repeat (2) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;
    resetModel();

    $display("[TB] idle scan");
    idle(3 * 8 * DIV[0]);

    $display("[TB] single frame");
    d0 = done_cnt[0];
    sendFrame(64'h8142241818244281, 64);
    checkCount(done_cnt[0] - d0, 1, "pattern_done_pulses");
    idle(8 * DIV[0] + 4);
    checkRowCol(0, 0, 8'h81, "pattern_row0");
    checkRowCol(0, 3, 8'h18, "pattern_row3");

    $display("[TB] aborted partial frame then all-ones");
    d0 = done_cnt[0];
    e0 = err_cnt[0];
    sendFrame(64'h00000000000F0F0F, 20);
    sendFrame(64'hFFFFFFFFFFFFFFFF, 64);
    checkCount(err_cnt[0] - e0, 1, "resync_err_pulses");
    checkCount(done_cnt[0] - d0, 1, "resync_done_pulses");
    idle(8 * DIV[0] + 4);
    for (int r = 0; r < 8; r++) begin
      checkRowCol(0, r, 8'hFF, "ones_row");
    end

    $display("[TB] two frames within one slow scan period");
    guard = 0;
    while (cyc % (8 * DIV[1]) != 0 && guard < 8 * DIV[1] + 8) begin
      idle(1);
      guard++;
    end
    checkCount(cyc % (8 * DIV[1]), 0, "ab_align");
    d0 = done_cnt[1];
    sendFrame(frame_a, 64);
    sendFrame(frame_b, 64);
    checkCount(done_cnt[1] - d0, 2, "ab_done_pulses");
    idle(140);
    checkRowCol(1, 0, frame_b[7:0], "ab_row0");
    checkRowCol(1, 6, frame_b[55:48], "ab_row6");

    $display("[TB] blank mid-row");
    idle(6);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkCount(int'(row_n_o[0]), 255, "blank_row_n_fast");
      checkCount(int'(row_n_o[1]), 255, "blank_row_n_slow");
    end
    idle(40);

    $display("[TB] async reset mid-capture");
    sendFrame(64'h5555555555555555, 40);
    #1 rst_n = 1'b0;
    #1 checkReset("async");
    @(negedge clk);
    @(negedge clk);
    checkReset("held");
    rst_n = 1'b1;
    resetModel();
    checkRowCol(0, 2, 8'h00, "post_reset_row2");
    d0 = done_cnt[0];
    sendFrame(frame_c, 64);
    checkCount(done_cnt[0] - d0, 1, "post_reset_done_pulses");
    idle(8 * DIV[0] + 4);
    checkRowCol(0, 0, frame_c[7:0], "post_reset_row0");
    checkRowCol(0, 7, frame_c[63:56], "post_reset_row7");
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
